// File: rtl/uart_acq_pkg.sv
// ============================================================================
// Module  : uart_acq_pkg
// Brief   : Shared state encodings and default command bytes for the
//           UART-triggered acquire controller.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_acq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        ACQ  = 2'd2
    } acq_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    localparam logic [7:0] CMD_WAVE  = 8'h77;
    localparam logic [7:0] CMD_FIR   = 8'h69;
    localparam logic [7:0] CMD_ABORT = 8'h78;

endpackage

`default_nettype wire

// File: rtl/uart_rx_byte.sv
// ============================================================================
// Module  : uart_rx_byte
// Brief   : Two-flop synchroniser plus 8N1 receiver with mid-bit sampling,
//           false-start rejection and stop-bit framing check.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_byte
    import uart_acq_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_rx,
    output logic       o_rx_valid,
    output logic [7:0] o_rx_byte,
    output logic       o_frame_err
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);

    logic             r_sync1;
    logic             r_rx_s;
    logic             r_rx_prev;
    rx_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bitn;
    logic [7:0]       r_shift;

    // A start is a high-to-low edge, so after a framing error the line must
    // return high before another byte can begin.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1     <= 1'b1;
            r_rx_s      <= 1'b1;
            r_rx_prev   <= 1'b1;
            r_state     <= RX_IDLE;
            r_cnt       <= '0;
            r_bitn      <= '0;
            r_shift     <= '0;
            o_rx_valid  <= 1'b0;
            o_rx_byte   <= '0;
            o_frame_err <= 1'b0;
        end else begin
            r_sync1     <= i_rx;
            r_rx_s      <= r_sync1;
            r_rx_prev   <= r_rx_s;
            o_rx_valid  <= 1'b0;
            o_frame_err <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    if (!r_rx_s && r_rx_prev) begin
                        r_state <= RX_START;
                        r_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (r_cnt == CNT_W'(HALF - 1)) begin
                        r_cnt   <= '0;
                        r_bitn  <= '0;
                        r_state <= r_rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (r_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                        r_cnt   <= '0;
                        r_shift <= {r_rx_s, r_shift[7:1]};
                        r_bitn  <= r_bitn + 3'd1;
                        if (r_bitn == 3'd7) begin
                            r_state <= RX_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (r_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                        r_cnt   <= '0;
                        r_state <= RX_IDLE;
                        if (r_rx_s) begin
                            o_rx_valid <= 1'b1;
                            o_rx_byte  <= r_shift;
                        end else begin
                            o_frame_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_acquire_ctrl.sv
// ============================================================================
// Module  : uart_acquire_ctrl
// Brief   : Decodes UART command bytes into per-channel active-low acquire
//           windows gated on a fresh waveform number.
//           Optional: define CMD_ABORT_EN to let ABORT_CODE cancel ARM/ACQ.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_acquire_ctrl
    import uart_acq_pkg::*;
#(
    parameter int                    CLKS_PER_BIT = 4,
    parameter int                    NUM_CH       = 2,
    parameter logic [8*NUM_CH-1:0]   CMD_CODES    = {CMD_FIR, CMD_WAVE},
    parameter int                    WINDOW_LEN   = 36050,
    parameter int                    WN_W         = 16,
    parameter logic [7:0]            ABORT_CODE   = CMD_ABORT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              uart_rx,
    input  logic [WN_W-1:0]   wavenum,
    output logic [NUM_CH-1:0] acquire_n,
    output logic [7:0]        char,
    output logic [WN_W-1:0]   last_wavenum,
    output logic              busy,
    output logic              frame_err,
    output logic              cmd_err
);

    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(WINDOW_LEN + 1);
    localparam logic [NUM_CH-1:0] c_ACQ_OFF = '1;
    localparam logic [NUM_CH-1:0] c_ONE_HOT = NUM_CH'(1);
`ifdef CMD_ABORT_EN
    localparam logic c_ABORT_EN = 1'b1;
`else
    localparam logic c_ABORT_EN = 1'b0;
`endif

    logic              w_rx_valid;
    logic [7:0]        w_rx_byte;
    logic              w_match;
    logic [SEL_W-1:0]  w_sel;
    logic              w_abort;

    acq_state_t        r_state;
    logic [SEL_W-1:0]  r_sel;
    logic [CNT_W-1:0]  r_win_cnt;
    logic [NUM_CH-1:0] r_acquire_n;
    logic [WN_W-1:0]   r_last_wn;
    logic              r_busy;
    logic              r_cmd_err;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk         (clk),
        .reset       (reset),
        .i_rx        (uart_rx),
        .o_rx_valid  (w_rx_valid),
        .o_rx_byte   (w_rx_byte),
        .o_frame_err (frame_err)
    );

    // Scan from the top down so the lowest matching channel wins.
    always_comb begin
        w_match = 1'b0;
        w_sel   = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (w_rx_byte == CMD_CODES[8*k +: 8]) begin
                w_match = 1'b1;
                w_sel   = SEL_W'(k);
            end
        end
    end

    assign w_abort = c_ABORT_EN && w_rx_valid && (w_rx_byte == ABORT_CODE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_sel       <= '0;
            r_win_cnt   <= '0;
            r_acquire_n <= c_ACQ_OFF;
            r_last_wn   <= '0;
            r_busy      <= 1'b0;
            r_cmd_err   <= 1'b0;
        end else begin
            r_cmd_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_rx_valid) begin
                        if (w_match) begin
                            r_sel   <= w_sel;
                            r_state <= ARM;
                            r_busy  <= 1'b1;
                        end else begin
                            r_cmd_err <= 1'b1;
                        end
                    end
                end
                ARM: begin
                    if (w_abort) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (wavenum != r_last_wn) begin
                        r_state     <= ACQ;
                        r_win_cnt   <= '0;
                        r_acquire_n <= ~(c_ONE_HOT << r_sel);
                    end
                end
                ACQ: begin
                    if (w_abort) begin
                        r_acquire_n <= c_ACQ_OFF;
                        r_state     <= IDLE;
                        r_busy      <= 1'b0;
                    end else if (r_win_cnt == CNT_W'(WINDOW_LEN - 1)) begin
                        r_acquire_n <= c_ACQ_OFF;
                        r_last_wn   <= wavenum;
                        r_state     <= IDLE;
                        r_busy      <= 1'b0;
                    end else if (r_win_cnt != CNT_W'(WINDOW_LEN)) begin
                        r_win_cnt <= r_win_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_acquire_n <= c_ACQ_OFF;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign acquire_n    = r_acquire_n;
    assign char         = w_rx_byte;
    assign last_wavenum = r_last_wn;
    assign busy         = r_busy;
    assign cmd_err      = r_cmd_err;

endmodule

`default_nettype wire

// File: tb/tb_uart_acquire_ctrl.sv
// ============================================================================
// Module  : tb_uart_acquire_ctrl
// Brief   : Directed table-driven bench for uart_acquire_ctrl
//           (CLKS_PER_BIT=4, NUM_CH=2, WINDOW_LEN=16); honours CMD_ABORT_EN.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_acquire_ctrl;

    logic        clk;
    logic        reset;
    logic        uart_rx;
    logic [15:0] wavenum;
    logic [1:0]  acquire_n;
    logic [7:0]  char;
    logic [15:0] last_wavenum;
    logic        busy;
    logic        frame_err;
    logic        cmd_err;

    uart_acquire_ctrl #(
        .CLKS_PER_BIT (4),
        .NUM_CH       (2),
        .CMD_CODES    (16'h6977),
        .WINDOW_LEN   (16),
        .WN_W         (16),
        .ABORT_CODE   (8'h78)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .uart_rx      (uart_rx),
        .wavenum      (wavenum),
        .acquire_n    (acquire_n),
        .char         (char),
        .last_wavenum (last_wavenum),
        .busy         (busy),
        .frame_err    (frame_err),
        .cmd_err      (cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: samples 1 ns after each rising edge; cyc = rising edges seen.
    int         cyc = 0;
    int         ferr_cnt = 0;
    int         cerr_cnt = 0;
    int         win_cnt = 0;
    int         win_len = 0;
    int         win_first = 0;
    logic [1:0] win_pat = 2'b11;
    logic       prev_low = 1'b0;

    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (frame_err) ferr_cnt++;
        if (cmd_err) cerr_cnt++;
        if (acquire_n != 2'b11) begin
            if (!prev_low) begin
                win_cnt++;
                win_first = cyc;
                win_pat   = acquire_n;
                win_len   = 0;
            end
            win_len++;
            prev_low = 1'b1;
        end else begin
            prev_low = 1'b0;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called on a falling edge; drives a full 10-bit frame.
    task automatic send_byte(input logic [7:0] d, input logic stop);
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            repeat (4) @(negedge clk);
        end
        uart_rx = stop;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    typedef struct {
        logic [7:0]  data;
        logic        stop;
        logic [15:0] wn;
        logic [7:0]  exp_char;
        int          exp_ferr;
        int          exp_cerr;
        int          exp_win;
        logic [1:0]  exp_pat;
        logic [15:0] exp_last;
    } vec_t;

    vec_t vecs [6];

    int s_ferr, s_cerr, s_win, t0, waited;

    task automatic snap();
        s_ferr = ferr_cnt;
        s_cerr = cerr_cnt;
        s_win  = win_cnt;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h77, 1'b1, 16'd5, 8'h77, 0, 0, 1, 2'b10, 16'd5};
        vecs[1] = '{8'h41, 1'b0, 16'd5, 8'h77, 1, 0, 0, 2'b11, 16'd5};
        vecs[2] = '{8'h41, 1'b1, 16'd5, 8'h41, 0, 1, 0, 2'b11, 16'd5};
        vecs[3] = '{8'h69, 1'b1, 16'd9, 8'h69, 0, 0, 1, 2'b01, 16'd9};
        vecs[4] = '{8'h00, 1'b1, 16'd9, 8'h00, 0, 1, 0, 2'b11, 16'd9};
        vecs[5] = '{8'hFF, 1'b1, 16'd9, 8'hFF, 0, 1, 0, 2'b11, 16'd9};

        reset   = 1'b1;
        uart_rx = 1'b1;
        wavenum = 16'd0;
        repeat (3) @(negedge clk);
        check("rst_acquire_n", 32'(acquire_n), 32'h3);
        check("rst_char", 32'(char), 32'h0);
        check("rst_last_wn", 32'(last_wavenum), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_cmd_err", 32'(cmd_err), 32'h0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Table: stop sample at t0+41, acquire low from t0+43 for 16 cycles.
        for (int v = 0; v < 6; v++) begin
            wavenum = vecs[v].wn;
            snap();
            t0 = cyc;
            send_byte(vecs[v].data, vecs[v].stop);
            repeat (25) @(negedge clk);
            check($sformatf("v%0d_char", v), 32'(char), 32'(vecs[v].exp_char));
            check($sformatf("v%0d_frame_err", v), 32'(ferr_cnt - s_ferr), 32'(vecs[v].exp_ferr));
            check($sformatf("v%0d_cmd_err", v), 32'(cerr_cnt - s_cerr), 32'(vecs[v].exp_cerr));
            check($sformatf("v%0d_windows", v), 32'(win_cnt - s_win), 32'(vecs[v].exp_win));
            if (vecs[v].exp_win != 0) begin
                check($sformatf("v%0d_pattern", v), 32'(win_pat), 32'(vecs[v].exp_pat));
                check($sformatf("v%0d_len", v), 32'(win_len), 32'd16);
                check($sformatf("v%0d_latency", v), 32'(win_first - t0), 32'd43);
            end
            check($sformatf("v%0d_last_wn", v), 32'(last_wavenum), 32'(vecs[v].exp_last));
            check($sformatf("v%0d_busy", v), 32'(busy), 32'h0);
            check($sformatf("v%0d_acquire_idle", v), 32'(acquire_n), 32'h3);
        end

        // ARM holds while wavenum equals last_wavenum (9).
        snap();
        send_byte(8'h69, 1'b1);
        repeat (30) @(negedge clk);
        check("arm_busy", 32'(busy), 32'h1);
        check("arm_acquire_n", 32'(acquire_n), 32'h3);
        check("arm_no_window", 32'(win_cnt - s_win), 32'h0);
        t0 = cyc;
        wavenum = 16'd10;
        repeat (25) @(negedge clk);
        check("arm_windows", 32'(win_cnt - s_win), 32'h1);
        check("arm_pattern", 32'(win_pat), 32'h1);
        check("arm_latency", 32'(win_first - t0), 32'd1);
        check("arm_len", 32'(win_len), 32'd16);
        check("arm_last_wn", 32'(last_wavenum), 32'd10);
        check("arm_busy_done", 32'(busy), 32'h0);

        // Single-cycle glitch must be rejected as a false start.
        snap();
        uart_rx = 1'b0;
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (50) @(negedge clk);
        check("glitch_frame_err", 32'(ferr_cnt - s_ferr), 32'h0);
        check("glitch_cmd_err", 32'(cerr_cnt - s_cerr), 32'h0);
        check("glitch_windows", 32'(win_cnt - s_win), 32'h0);
        check("glitch_busy", 32'(busy), 32'h0);
        check("glitch_char", 32'(char), 32'h69);

        // Reset on the 8th ACQ cycle.
        wavenum = 16'd11;
        snap();
        send_byte(8'h77, 1'b1);
        waited = 0;
        while (!((win_cnt != s_win) && (win_len == 8)) && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("rstacq_reached_cycle8", 32'(waited < 100), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        check("rstacq_acquire_n", 32'(acquire_n), 32'h3);
        check("rstacq_busy", 32'(busy), 32'h0);
        check("rstacq_last_wn", 32'(last_wavenum), 32'h0);
        check("rstacq_char", 32'(char), 32'h0);
        reset = 1'b0;
        @(negedge clk);
        wavenum = 16'd7;
        snap();
        t0 = cyc;
        send_byte(8'h77, 1'b1);
        repeat (25) @(negedge clk);
        check("post_rst_windows", 32'(win_cnt - s_win), 32'h1);
        check("post_rst_pattern", 32'(win_pat), 32'h2);
        check("post_rst_len", 32'(win_len), 32'd16);
        check("post_rst_latency", 32'(win_first - t0), 32'd43);
        check("post_rst_last_wn", 32'(last_wavenum), 32'd7);

        // 'x' lands on the 10th ACQ cycle: park in ARM, then release wavenum.
        snap();
        send_byte(8'h77, 1'b1);
        repeat (5) @(negedge clk);
        check("abort_arm_busy", 32'(busy), 32'h1);
        t0 = cyc;
        fork
            send_byte(8'h78, 1'b1);
            begin
                repeat (31) @(negedge clk);
                wavenum = 16'd8;
            end
        join
        repeat (30) @(negedge clk);
        check("abort_windows", 32'(win_cnt - s_win), 32'h1);
        check("abort_start", 32'(win_first - t0), 32'd32);
        check("abort_pattern", 32'(win_pat), 32'h2);
        check("abort_cmd_err", 32'(cerr_cnt - s_cerr), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_acquire_n", 32'(acquire_n), 32'h3);
`ifdef CMD_ABORT_EN
        check("abort_len", 32'(win_len), 32'd10);
        check("abort_last_wn", 32'(last_wavenum), 32'd7);
`else
        check("abort_len", 32'(win_len), 32'd16);
        check("abort_last_wn", 32'(last_wavenum), 32'd8);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
